// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end for a single-port,
// async-read RAM. Each access is IDLE (decide) -> ACCESS (drive RAM) ->
// ACK (one-cycle pulse to the winner), so at most one access per 3 cycles.
module ram_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      wdata0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  ack1,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t                r_state, w_next;
  logic                  r_ptr;    // 0: req0 preferred on a tie, 1: req1
  logic                  r_id;     // winner of the access in flight
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_ack0, r_ack1;

  logic w_any, w_grant;

  // Winner selection: a lone requester always wins; a tie goes to the pointer.
  assign w_any   = req0 | req1;
  assign w_grant = (req0 & req1) ? r_ptr : req1;

  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign rdata    = r_rdata;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and RAM write strobe / busy decode.
  always_comb begin
    w_next = r_state;
    ram_we = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: begin
        w_next = S_ACK;
        ram_we = r_we;
        busy   = 1'b1;
      end
      S_ACK: begin
        w_next = S_IDLE;
        busy   = 1'b1;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latch, read capture, ack pulse and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_grant;
            r_we    <= w_grant ? we1    : we0;
            r_addr  <= w_grant ? addr1  : addr0;
            r_wdata <= w_grant ? wdata1 : wdata0;
          end
        end
        S_ACCESS: begin
          if (!r_we) r_rdata <= ram_dout;
          r_ack0 <= ~r_id;
          r_ack1 <= r_id;
        end
        S_ACK: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_ptr  <= ~r_id;   // only a completed access moves the pointer
        end
        default: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives two requesters with random reads/writes and checks
// every cycle of every access against a memory/pointer model.
module tb_ram_arbiter;
  localparam int W  = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          ack0, ack1, busy, ram_we;
  logic [W-1:0]  rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic [W-1:0]  ram [256] = '{default: '0};

  ram_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Simulation RAM: sync write, async read, no reset.
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;
  assign ram_dout = ram[ram_addr];

  // Reference model
  logic [W-1:0]  mem_ref [256];
  bit            ptr_ref;
  logic [W-1:0]  rdata_ref;
  bit            op_we [2];
  logic [AW-1:0] op_a  [2];
  logic [W-1:0]  op_d  [2];
  int            checks = 0;
  int            failures = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply(input int id);
    if (id == 0) begin we0 = op_we[0]; addr0 = op_a[0]; wdata0 = op_d[0]; end
    else         begin we1 = op_we[1]; addr1 = op_a[1]; wdata1 = op_d[1]; end
  endtask

  task automatic scramble(input int id);
    if (id == 0) begin we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = W'($urandom); end
    else         begin we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = W'($urandom); end
  endtask

  task automatic new_op(input int id);
    op_we[id] = 1'($urandom_range(0, 1));
    op_a[id]  = AW'($urandom_range(0, 63));
    op_d[id]  = W'($urandom);
  endtask

  // Serve n grants with requester 0/1 held per h0/h1; each grant is checked
  // over its ACCESS, ACK and following IDLE cycle.
  task automatic run_held(input bit h0, input bit h1, input int n);
    int w;
    req0 = h0; req1 = h1; apply(0); apply(1);
    for (int g = 0; g < n; g++) begin
      w = (h0 && h1) ? int'(ptr_ref) : (h1 ? 1 : 0);
      step();  // ACCESS
      checks++;
      if (ram_we !== op_we[w] || ram_addr !== op_a[w] || busy !== 1'b1 ||
          ack0 !== 1'b0 || ack1 !== 1'b0) begin
        failures++;
        $display("FAIL access g=%0d w=%0d: we=%b addr=%h busy=%b ack=%b%b, want we=%b addr=%h busy=1 ack=00",
                 g, w, ram_we, ram_addr, busy, ack0, ack1, op_we[w], op_a[w]);
      end
      if (op_we[w]) begin
        checks++;
        if (ram_din !== op_d[w]) begin
          failures++;
          $display("FAIL din g=%0d: got %h want %h", g, ram_din, op_d[w]);
        end
      end
      scramble(w);
      step();  // ACK
      if (op_we[w]) mem_ref[op_a[w]] = op_d[w];
      else          rdata_ref = mem_ref[op_a[w]];
      ptr_ref = (w == 0);
      checks++;
      if (ack0 !== (w == 0) || ack1 !== (w == 1) || ram_we !== 1'b0 ||
          busy !== 1'b1 || ram_addr !== op_a[w]) begin
        failures++;
        $display("FAIL ack g=%0d w=%0d: ack=%b%b we=%b busy=%b addr=%h, want ack0=%0d ack1=%0d we=0 busy=1 addr=%h",
                 g, w, ack0, ack1, ram_we, busy, ram_addr, w == 0, w == 1, op_a[w]);
      end
      checks++;
      if (rdata !== rdata_ref) begin
        failures++;
        $display("FAIL rdata g=%0d: got %h want %h", g, rdata, rdata_ref);
      end
      if (g == n - 1) begin req0 = 1'b0; req1 = 1'b0; end
      else begin new_op(w); apply(w); end
      step();  // IDLE
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0 ||
          rdata !== rdata_ref) begin
        failures++;
        $display("FAIL idle g=%0d: ack=%b%b busy=%b we=%b rdata=%h, want 00 0 0 %h",
                 g, ack0, ack1, busy, ram_we, rdata, rdata_ref);
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    rst = 1'b1; ptr_ref = 1'b0; rdata_ref = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    we0 = 1'b1; we1 = 1'b1; addr0 = 8'h05; addr1 = 8'h06;
    wdata0 = 16'h1111; wdata1 = 16'h2222;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || ram_we !== 1'b0 || rdata !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset c=%0d: ack=%b%b we=%b rdata=%h busy=%b, want all zero",
                 i, ack0, ack1, ram_we, rdata, busy);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
    ptr_ref = 1'b0; rdata_ref = '0;
    step();
  endtask

  task automatic test_write_read();
    op_we[0] = 1'b1; op_a[0] = 8'h10; op_d[0] = 16'hBEEF;
    run_held(1'b1, 1'b0, 1);
    op_we[0] = 1'b0; op_a[0] = 8'h10; op_d[0] = 16'h0000;
    run_held(1'b1, 1'b0, 1);
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL readback_10: got %h want BEEF", rdata);
    end
  endtask

  task automatic test_both();
    reset_dut();
    new_op(0); new_op(1);
    run_held(1'b1, 1'b1, 8);
  endtask

  task automatic test_only1();
    new_op(1);
    run_held(1'b0, 1'b1, 5);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      new_op(0); new_op(1);
      run_held(1'b1, 1'b1, 3 + r);
    end
  endtask

  task automatic test_hold_inputs();
    op_we[0] = 1'b1; op_a[0] = 8'h30; op_d[0] = 16'hA5A5;
    run_held(1'b1, 1'b0, 1);
    op_we[0] = 1'b0;
    run_held(1'b1, 1'b0, 1);
    checks++;
    if (rdata !== 16'hA5A5) begin
      failures++;
      $display("FAIL readback_30: got %h want A5A5", rdata);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h22; wdata0 = 16'h1234;
    step();  // ACCESS
    checks++;
    if (ram_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_we: got %b want 1", ram_we);
    end
    rst = 1'b0; req0 = 1'b0;
    step();
    mem_ref[8'h22] = 16'h1234; ptr_ref = 1'b0; rdata_ref = '0;
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0 || rdata !== '0) begin
      failures++;
      $display("FAIL mid_reset: ack=%b%b busy=%b we=%b rdata=%h, want all zero",
               ack0, ack1, busy, ram_we, rdata);
    end
    step();
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_noack: ack=%b%b want 00", ack0, ack1);
    end
    rst = 1'b1;
    step();
    op_we[0] = 1'b0; op_a[0] = 8'h22; op_d[0] = '0;
    run_held(1'b1, 1'b0, 1);
    checks++;
    if (rdata !== 16'h1234) begin
      failures++;
      $display("FAIL readback_22: got %h want 1234", rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_ref[i] = '0;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1;
    test_reset();
    test_write_read();
    test_both();
    test_only1();
    test_back_to_back();
    test_hold_inputs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
